// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared state codes, key enumeration and IR cmd-to-key table
// Contents: state_t (FSM codes), key_t (decoded keys), CMD_* remote cmd bytes,
//           cmd_to_key() table lookup, is_digit() helper.
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    KEY_D0   = 4'd0,
    KEY_D1   = 4'd1,
    KEY_D2   = 4'd2,
    KEY_D3   = 4'd3,
    KEY_D4   = 4'd4,
    KEY_D5   = 4'd5,
    KEY_D6   = 4'd6,
    KEY_D7   = 4'd7,
    KEY_D8   = 4'd8,
    KEY_D9   = 4'd9,
    KEY_CLR  = 4'd10,
    KEY_BS   = 4'd11,
    KEY_ENT  = 4'd12,
    KEY_NONE = 4'd15
  } key_t;

  localparam logic [2:0] NUM_DIGITS = 3'd6;

  // Command bytes of the handheld remote
  localparam logic [7:0] CMD_D0  = 8'h16;
  localparam logic [7:0] CMD_D1  = 8'h0C;
  localparam logic [7:0] CMD_D2  = 8'h18;
  localparam logic [7:0] CMD_D3  = 8'h5E;
  localparam logic [7:0] CMD_D4  = 8'h08;
  localparam logic [7:0] CMD_D5  = 8'h1C;
  localparam logic [7:0] CMD_D6  = 8'h5A;
  localparam logic [7:0] CMD_D7  = 8'h42;
  localparam logic [7:0] CMD_D8  = 8'h52;
  localparam logic [7:0] CMD_D9  = 8'h4A;
  localparam logic [7:0] CMD_CLR = 8'h45;
  localparam logic [7:0] CMD_BS  = 8'h44;
  localparam logic [7:0] CMD_ENT = 8'h40;

  function automatic key_t cmd_to_key(input logic [7:0] cmd);
    case (cmd)
      CMD_D0:  return KEY_D0;
      CMD_D1:  return KEY_D1;
      CMD_D2:  return KEY_D2;
      CMD_D3:  return KEY_D3;
      CMD_D4:  return KEY_D4;
      CMD_D5:  return KEY_D5;
      CMD_D6:  return KEY_D6;
      CMD_D7:  return KEY_D7;
      CMD_D8:  return KEY_D8;
      CMD_D9:  return KEY_D9;
      CMD_CLR: return KEY_CLR;
      CMD_BS:  return KEY_BS;
      CMD_ENT: return KEY_ENT;
      default: return KEY_NONE;
    endcase
  endfunction

  function automatic logic is_digit(input key_t k);
    return k <= KEY_D9;
  endfunction

endpackage

// File: rtl/ir_cmd_ctrl_if.sv
// rtl/ir_cmd_ctrl_if.sv - frame input and keypad-entry outputs of ir_cmd_ctrl
// Signals: i_frame/i_frame_vld (decoded IR frame strobe), o_disp/o_dp (live
//          entry and cursor), o_value/o_commit (committed value), o_timeout,
//          o_err, o_state. slave = controller side, master = frame source/sink.
interface ir_cmd_ctrl_if;
  logic [31:0] i_frame;
  logic        i_frame_vld;
  logic [23:0] o_disp;
  logic [5:0]  o_dp;
  logic [23:0] o_value;
  logic        o_commit;
  logic        o_timeout;
  logic        o_err;
  logic [1:0]  o_state;

  modport master (
    output i_frame, i_frame_vld,
    input  o_disp, o_dp, o_value, o_commit, o_timeout, o_err, o_state
  );

  modport slave (
    input  i_frame, i_frame_vld,
    output o_disp, o_dp, o_value, o_commit, o_timeout, o_err, o_state
  );
endinterface

// File: rtl/ir_frame_chk.sv
// rtl/ir_frame_chk.sv - combinational IR frame validity check and key decode
// Ports: frame (in, 32) {addr, ~addr, cmd, ~cmd}; valid (out) address and
//        complements match; key (out) decoded key, KEY_NONE if unmapped.
module ir_frame_chk
  import ir_pkg::*;
#(
  parameter logic [7:0] P_ADDR = 8'h00
) (
  input  logic [31:0] frame,
  output logic        valid,
  output key_t        key
);

  assign valid = (frame[31:24] == P_ADDR) &&
                 (frame[23:16] == ~frame[31:24]) &&
                 (frame[7:0]   == ~frame[15:8]);

  assign key = cmd_to_key(frame[15:8]);

endmodule

// File: rtl/ir_cmd_ctrl.sv
// rtl/ir_cmd_ctrl.sv - IR remote keypad entry controller (six BCD digits)
// Ports: clk, rst (sync active-high); bus (ir_cmd_ctrl_if.slave) carrying
//        the frame strobe in and display/value/pulse/state outputs.
module ir_cmd_ctrl
  import ir_pkg::*;
#(
  parameter logic [7:0]  P_ADDR    = 8'h00,
  parameter logic [31:0] P_TIMEOUT = 32'd250_000_000,
  parameter logic [31:0] P_HOLDOFF = 32'd10_000_000
) (
  input  logic          clk,
  input  logic          rst,
  ir_cmd_ctrl_if.slave  bus
);

  logic        frame_ok;
  key_t        key;
  logic [3:0]  key_val;
  state_t      state, nxt_state;
  logic [23:0] entry, entry_d, value;
  logic [2:0]  cnt, cnt_d;
  logic [31:0] to_cnt, hold_cnt, last_frame;
  logic        hold_act;
  logic        err_q, err_d, tmo_q, tmo_d, commit_q, commit_d;
  logic        mapped_ok, rpt, key_go, to_exp;
  logic [5:0]  dp;

  ir_frame_chk #(.P_ADDR(P_ADDR)) u_chk (
    .frame (bus.i_frame),
    .valid (frame_ok),
    .key   (key)
  );

  assign key_val   = key;
  assign mapped_ok = bus.i_frame_vld && frame_ok && (key != KEY_NONE);
  // Identical resend inside the holdoff window is a key-repeat burst: drop silently
  assign rpt       = hold_act && (bus.i_frame == last_frame) && (hold_cnt < P_HOLDOFF);
  assign key_go    = mapped_ok && !rpt;
  assign to_exp    = (state == ST_ENTRY) && (to_cnt == P_TIMEOUT - 32'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:
        if (key_go && is_digit(key)) nxt_state = ST_ENTRY;
      ST_ENTRY:
        if (key_go) begin
          case (key)
            KEY_ENT: nxt_state = ST_COMMIT;
            KEY_CLR: nxt_state = ST_IDLE;
            KEY_BS:  if (cnt == 3'd1) nxt_state = ST_IDLE;
            default: nxt_state = ST_ENTRY;
          endcase
        end else if (to_exp) begin
          nxt_state = ST_IDLE;
        end
      ST_COMMIT: nxt_state = ST_IDLE;
      default:   nxt_state = ST_IDLE;
    endcase
  end

  // Output / datapath decode
  always_comb begin
    entry_d  = entry;
    cnt_d    = cnt;
    err_d    = bus.i_frame_vld && !(frame_ok && key != KEY_NONE);
    tmo_d    = 1'b0;
    commit_d = 1'b0;
    case (state)
      ST_IDLE:
        if (key_go) begin
          if (is_digit(key)) begin
            entry_d = {20'h0, key_val};
            cnt_d   = 3'd1;
          end else if (key == KEY_ENT) begin
            err_d = 1'b1;
          end
        end
      ST_ENTRY:
        if (key_go) begin
          case (key)
            KEY_ENT: ;  // buffer held for the COMMIT cycle
            KEY_CLR: begin
              entry_d = '0;
              cnt_d   = '0;
            end
            KEY_BS: begin
              entry_d = {4'h0, entry[23:4]};
              cnt_d   = cnt - 3'd1;
            end
            default:
              if (cnt == NUM_DIGITS) begin
                err_d = 1'b1;
              end else begin
                entry_d = {entry[19:0], key_val};
                cnt_d   = cnt + 3'd1;
              end
          endcase
        end else if (to_exp) begin
          entry_d = '0;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end
      ST_COMMIT: begin
        commit_d = 1'b1;
        entry_d  = '0;
        cnt_d    = '0;
      end
      default: begin
        entry_d = '0;
        cnt_d   = '0;
      end
    endcase
    dp = (state == ST_ENTRY && cnt < NUM_DIGITS) ? (6'd1 << cnt) : 6'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry    <= '0;
      cnt      <= '0;
      value    <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      entry    <= entry_d;
      cnt      <= cnt_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      commit_q <= commit_d;
      if (commit_d) value <= entry;
    end
  end

  // Idle timer: cleared by any accepted key, runs only while an entry is open
  always_ff @(posedge clk) begin
    if (rst || key_go || state != ST_ENTRY || to_exp) to_cnt <= '0;
    else                                              to_cnt <= to_cnt + 32'd1;
  end

  // Holdoff: cycles since the last accepted frame, saturating at P_HOLDOFF
  always_ff @(posedge clk) begin
    if (rst) begin
      last_frame <= '0;
      hold_act   <= 1'b0;
      hold_cnt   <= '0;
    end else if (key_go) begin
      last_frame <= bus.i_frame;
      hold_act   <= 1'b1;
      hold_cnt   <= 32'd1;
    end else if (hold_cnt < P_HOLDOFF) begin
      hold_cnt <= hold_cnt + 32'd1;
    end
  end

  assign bus.o_disp    = entry;
  assign bus.o_dp      = dp;
  assign bus.o_value   = value;
  assign bus.o_commit  = commit_q;
  assign bus.o_timeout = tmo_q;
  assign bus.o_err     = err_q;
  assign bus.o_state   = state;

endmodule

// File: doc/ir_cmd_ctrl.md
IR_CMD_CTRL -- requirements
Module: ir_cmd_ctrl

Interface
REQ-001 Parameter P_ADDR, default 8'h00, accepted IR custom (address) code.
REQ-002 Parameter P_TIMEOUT, default 32'd250_000_000, idle cycles before an entry is abandoned (5 s at 50 MHz).
REQ-003 Parameter P_HOLDOFF, default 32'd10_000_000, cycles during which an identical repeated frame is ignored (200 ms).
REQ-004 clk  in  1  system clock, 50 MHz; sole clock of the block.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_frame  in  32  decoded IR frame {addr, ~addr, cmd, ~cmd}, addr in [31:24].
REQ-007 i_frame_vld  in  1  one-cycle strobe, i_frame valid.
REQ-008 o_disp  out  24  live entry buffer, six BCD digits, digit 0 in [3:0], for display decode.
REQ-009 o_dp  out  6  cursor marker, one-hot bit of the next free digit, 0 when idle or full.
REQ-010 o_value  out  24  last committed BCD value.
REQ-011 o_commit  out  1  one-cycle pulse when o_value updates.
REQ-012 o_timeout  out  1  one-cycle pulse when an entry is abandoned.
REQ-013 o_err  out  1  one-cycle pulse on a rejected frame or illegal key.
REQ-014 o_state  out  2  current FSM state code.

Function
REQ-015 A frame SHALL be valid only if [31:24]==P_ADDR, [23:16]==~[31:24], and [7:0]==~[15:8]; an invalid frame SHALL pulse o_err and change no other state.
REQ-016 A valid cmd byte SHALL map to a key: DIGIT 0-9, CLR, BS, ENT; unmapped cmd SHALL pulse o_err and be dropped.
REQ-017 A valid frame equal to the previously accepted frame and arriving fewer than P_HOLDOFF cycles after it SHALL be ignored silently, with no o_err pulse; the holdoff counter saturates.
REQ-018 FSM states: IDLE=0, ENTRY=1, COMMIT=2; state 3 is unused and SHALL return to IDLE.
REQ-019 IDLE: a DIGIT key SHALL load the digit into [3:0], clear the upper digits, set count=1, and go to ENTRY; CLR/BS SHALL be no-ops; ENT SHALL pulse o_err.
REQ-020 ENTRY, DIGIT: shift the buffer left 4 bits, insert the digit at [3:0], count+1; at count==6 it SHALL be ignored with an o_err pulse.
REQ-021 ENTRY, BS: shift the buffer right 4 bits with zero fill, count-1; count reaching 0 SHALL go to IDLE.
REQ-022 ENTRY, CLR: buffer=0, count=0, go to IDLE.
REQ-023 ENTRY, ENT: go to COMMIT; COMMIT lasts exactly one cycle, loads o_value from the buffer, pulses o_commit, clears the buffer and count, then goes to IDLE.
REQ-024 Keys arriving in COMMIT SHALL be dropped.
REQ-025 Each accepted key SHALL take effect on o_disp/o_dp one cycle after the i_frame_vld cycle.
REQ-026 The timeout counter SHALL reset on every accepted key and increment each cycle in ENTRY; at P_TIMEOUT-1 it SHALL clear the buffer, pulse o_timeout, and go to IDLE.
REQ-027 If a key and timeout expiry coincide, the key wins; there is no timeout pulse.
REQ-028 o_dp SHALL equal 6'b1 << count in ENTRY with count<6, else 0.

Reset
REQ-029 When rst is high at a clock edge: state=IDLE, buffer=0, count=0, o_value=0, all pulses=0, counters=0, last-frame=0, and the holdoff window is expired.
REQ-030 Reset mid-entry SHALL discard the entry and SHALL NOT pulse o_commit.

Structure
REQ-031 The shared package ir_pkg SHALL hold the state codes, the key enumeration, and the cmd-to-key table constants.
REQ-032 A single sub-module ir_frame_chk SHALL be used: a combinational validity check plus key decode, producing {valid, key}.

Verification
REQ-033 Frames for 1,2,3 then ENT, with addr=P_ADDR -> o_disp 000123 during entry; o_commit pulses once; o_value=24'h000123.
REQ-034 Seven DIGIT 9 keys -> o_disp 999999; seventh key pulses o_err; o_dp=0 after the sixth key.
REQ-035 Digits 4,5 then BS, BS -> o_disp 000004, then 0; state IDLE after the second BS.
REQ-036 Frame with cmd complement corrupted -> o_err pulse; o_disp and state unchanged.
REQ-037 Same digit frame twice, 1000 cycles apart -> single entry; resent after P_HOLDOFF -> second digit accepted.
REQ-038 One digit, then idle P_TIMEOUT cycles -> o_timeout pulse, o_disp=0, IDLE; repeat with a key on the expiry cycle -> key applied, no o_timeout.
